// File: rtl/pr_bridge_pkg.sv
// Shared definitions for the processor-bus bridge: FSM state encoding and
// the default data word returned on an error completion.
package pr_bridge_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/pr_addr_dec.sv
// Combinational decoder: maps a 16-byte line address (byte address [31:4])
// onto a one-hot select over DEV_N consecutive device windows starting at BASE.
module pr_addr_dec
    import pr_bridge_pkg::*;
#(
    parameter int          DEV_N = 2,
    parameter logic [31:0] BASE  = 32'h0000_7F00
) (
    input  logic [27:0]      lineAddr,
    output logic             hit,
    output logic [DEV_N-1:0] sel
);

    localparam logic [27:0] BASE_LINE = BASE[31:4];

    always_comb begin
        sel = '0;
        for (int i = 0; i < DEV_N; i++) begin
            if (lineAddr == BASE_LINE + 28'(i)) begin
                sel[i] = 1'b1;
            end
        end
        hit = |sel;
    end

endmodule

// File: rtl/pr_bridge.sv
// Processor-bus bridge between the multi-cycle MIPS core and up to six
// memory-mapped peripherals, with a ready/timeout handshake and IRQ flops.
module pr_bridge
    import pr_bridge_pkg::*;
#(
    parameter int          DEV_N    = 2,
    parameter logic [31:0] BASE     = 32'h0000_7F00,
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PrReq,
    input  logic [29:0]           PrAddr,
    input  logic [3:0]            BE,
    input  logic [31:0]           PrWD,
    input  logic                  PrWe,
    output logic [31:0]           PrRD,
    output logic                  PrRdy,
    output logic                  PrErr,
    output logic [DEV_N-1:0]      DevSel,
    output logic [1:0]            DevAddr,
    output logic [3:0]            DevBE,
    output logic [31:0]           DevWD,
    output logic                  DevWe,
    input  logic [32*DEV_N-1:0]   DevRD,
    input  logic [DEV_N-1:0]      DevRdy,
    input  logic [DEV_N-1:0]      DevIrq,
    output logic [5:0]            HWInt
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       offLat;
    logic [3:0]       beLat;
    logic [31:0]      wdLat;
    logic             weLat;
    logic [DEV_N-1:0] selLat;
    logic             errLat;
    logic [31:0]      dataLat;
    logic [7:0]       cnt;
    logic [5:0]       irqReg;

    logic             decHit;
    logic [DEV_N-1:0] decSel;
    logic             devRdyHit;
    logic [31:0]      devData;
    logic [5:0]       irqVec;

    pr_addr_dec #(
        .DEV_N (DEV_N),
        .BASE  (BASE)
    ) uDec (
        .lineAddr (PrAddr[29:2]),
        .hit      (decHit),
        .sel      (decSel)
    );

    // Only the latched device's acknowledge and data are considered.
    always_comb begin
        devData = '0;
        for (int i = 0; i < DEV_N; i++) begin
            if (selLat[i]) begin
                devData = DevRD[32*i +: 32];
            end
        end
        devRdyHit = |(DevRdy & selLat);
    end

    always_comb begin
        irqVec = '0;
        irqVec[DEV_N-1:0] = DevIrq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            offLat  <= '0;
            beLat   <= '0;
            wdLat   <= '0;
            weLat   <= 1'b0;
            selLat  <= '0;
            errLat  <= 1'b0;
            dataLat <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (PrReq) begin
                        offLat <= PrAddr[1:0];
                        beLat  <= BE;
                        wdLat  <= PrWD;
                        weLat  <= PrWe;
                        selLat <= decSel;
                        cnt    <= '0;
                        if (decHit) begin
                            state <= ACCESS;
                        end else begin
                            errLat  <= 1'b1;
                            dataLat <= ERR_DATA;
                            state   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 8'd1;
                    if (devRdyHit) begin
                        errLat  <= 1'b0;
                        dataLat <= weLat ? 32'd0 : devData;
                        state   <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        errLat  <= 1'b1;
                        dataLat <= ERR_DATA;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Interrupt path runs independently of the access FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irqReg <= '0;
        end else begin
            irqReg <= irqVec;
        end
    end

    assign HWInt   = irqReg;
    assign DevSel  = (state == ACCESS) ? selLat : '0;
    assign DevWe   = (state == ACCESS) & weLat;
    assign DevAddr = offLat;
    assign DevBE   = beLat;
    assign DevWD   = wdLat;
    assign PrRdy   = (state == RESP);
    assign PrErr   = (state == RESP) & errLat;
    assign PrRD    = (state == RESP) ? dataLat : 32'd0;

endmodule

// File: doc/pr_bridge.md
Name: pr_bridge

Overview:
- Sequences every processor-bus access from the multi-cycle MIPS core to up to six memory-mapped peripherals.
- Latches the CPU request, decodes the address to a one-hot device select and runs a ready/timeout handshake with the device.
- Returns read data with a one-cycle completion strobe that the CPU controller waits on.
- Registers the peripheral interrupt lines into the core's HWInt[7:2] vector.

Parameters:
- DEV_N, 2, number of attached devices (1..6).
- BASE, 32'h0000_7F00, byte address of device 0; device i occupies BASE+16*i .. BASE+16*i+15 (4 words).
- TIMEOUT, 15, maximum wait cycles for DevRdy before an error completion (1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PrReq  in  1  CPU access request; held high until PrRdy.
- PrAddr  in  30  word address [31:2].
- BE  in  4  byte enables.
- PrWD  in  32  CPU write data.
- PrWe  in  1  1 = write, 0 = read.
- PrRD  out  32  read data, valid when PrRdy=1.
- PrRdy  out  1  one-cycle completion strobe.
- PrErr  out  1  error flag, valid with PrRdy (unmapped address or timeout).
- DevSel  out  DEV_N  one-hot device select.
- DevAddr  out  2  word offset inside the device.
- DevBE  out  4  latched byte enables.
- DevWD  out  32  latched write data.
- DevWe  out  1  write strobe, qualified by DevSel.
- DevRD  in  32*DEV_N  flattened read data; device i is bits [32i+31:32i].
- DevRdy  in  DEV_N  per-device acknowledge.
- DevIrq  in  DEV_N  per-device level interrupt.
- HWInt  out  6  interrupt vector to the core, [7:2].

Behaviour:
- Reset (async): state IDLE; all outputs 0, including HWInt; timeout counter 0; latches cleared. Reset mid-access aborts the access silently, with no PrRdy.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: when PrReq=1, latch PrAddr, BE, PrWD and PrWe. Hit condition: PrAddr[31:4] equals (BASE>>4)+i for some i<DEV_N.
  - On a hit, go to ACCESS.
  - On a miss, go to RESP with err=1 and data=ERR_DATA.
- ACCESS: DevSel[i]=1, DevAddr=latched PrAddr[3:2], DevWe=latched we, DevBE/DevWD from the latches. The counter increments every ACCESS cycle.
  - If DevRdy[i]=1, capture DevRD slice i (reads; writes capture 0) and go to RESP with err=0. Device ready in the first ACCESS cycle is legal.
  - Else, if the counter equals TIMEOUT-1, go to RESP with err=1 and data=ERR_DATA. Total ACCESS cycles are exactly TIMEOUT.
  - DevRdy on a non-selected device is ignored.
- RESP: PrRdy=1, PrRD=captured data, PrErr=err, for exactly one cycle. DevSel=0 and DevWe=0. Counter cleared. Next state is IDLE.
- Outside RESP: PrRdy=0, PrErr=0, PrRD=0.
- Minimum latency: request sampled at edge N (IDLE→ACCESS); ready in ACCESS gives PrRdy during the cycle after edge N+1. A miss gives PrRdy after one cycle.
- Back-to-back: PrReq still high in the first IDLE cycle after RESP starts a new access. The CPU deasserts PrReq in the cycle following PrRdy when it has no new access.
- Changes to PrAddr, PrWD or PrWe while busy are ignored; the latched values are used.
- Interrupts: HWInt[2+i] = DevIrq[i] registered through one flop, for i<DEV_N. Unused bits are 0. This path is independent of the FSM.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the ERR_DATA default constant.
- One sub-module, pr_addr_dec: combinational BASE/DEV_N decoder producing hit and a one-hot select from PrAddr[31:4].
- FSM, latches, counter and interrupt flops stay in pr_bridge.

Test Plan:
- Read hit: DEV_N=2; PrReq with PrAddr=0x7F14>>2, PrWe=0; DevRdy[1] high with DevRD[63:32]=0x1234_5678 → DevSel=2'b10, DevAddr=1; PrRdy one cycle later with PrRD=0x1234_5678, PrErr=0.
- Write with wait states: addr 0x7F08, PrWD=0xA5A5_0001, BE=4'b0011; DevRdy[0] asserted on the 4th ACCESS cycle → DevWe=1, DevWD/DevBE stable for 4 cycles; PrRdy=1, PrErr=0.
- Timeout: addr 0x7F00, DevRdy held 0 → exactly 15 ACCESS cycles, then PrRdy=1, PrErr=1, PrRD=0xDEAD_BEEF.
- Unmapped: addr 0x7F20 with DEV_N=2 → DevSel never asserted; PrRdy on the cycle after the request, PrErr=1.
- Reset mid-access: assert rst during ACCESS → DevSel=0, PrRdy=0 immediately; after release the FSM is IDLE and a new read completes normally.
- Interrupts: DevIrq=2'b10 → HWInt=6'b000010 one cycle later; DevIrq to 0 → HWInt=0 one cycle later, including while an access is in flight.
